lc3_console_io: RTL and testbench

Memory-mapped console device that responds to the LC-3 datapath's memory accesses at the standard keyboard/display addresses (xFE00–xFE06). The processor is the initiator; this block is the responder. It decodes MAR-side addresses, supplies read data for the MDR path, and accepts DDR/status writes. On its far side it provides a buffered keyboard byte stream input and a valid/ready display byte output, plus a level interrupt request.

---
 rtl/lc3_console_io.sv | 178 +++++++++++++++++
 tb/tb_lc3_console_io.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_console_io.sv
// LC-3 memory-mapped console: keyboard (KBSR/KBDR) and display (DSR/DDR) at xFE00-xFE06.
// Keyboard bytes are queued in a small FIFO ahead of the KBDR holding register; the display is a one-byte valid/ready source.
module lc3_console_io #(
    parameter int KB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic        io_hit,
    output logic [15:0] io_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        irq
);

    localparam int PW = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] KB_FULL_CNT = CW'(KB_DEPTH);
    localparam logic [15:0]   ADDR_KBSR   = 16'hFE00;
    localparam logic [15:0]   ADDR_KBDR   = 16'hFE02;
    localparam logic [15:0]   ADDR_DSR    = 16'hFE04;
    localparam logic [15:0]   ADDR_DDR    = 16'hFE06;

    typedef enum logic [0:0] {
        DSP_IDLE = 1'b0,
        DSP_BUSY = 1'b1
    } dsp_state_t;

    logic [7:0]    kb_mem_r [KB_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    kbdr_r;
    logic          kb_full_r;
    logic          kb_ie_r;
    logic          dsp_ie_r;
    dsp_state_t    dsp_state_r;
    logic [7:0]    dsp_data_r;

    logic push_s;
    logic pop_s;
    logic kbdr_read_s;
    logic wr_kbsr_s;
    logic wr_dsr_s;
    logic wr_ddr_s;
    logic dsp_rdy_s;
    logic wdata_unused_s;

    // Only bit 14 and the low byte of the write data carry meaning.
    assign wdata_unused_s = ^{cpu_wdata[15], cpu_wdata[13:8]};

    assign kb_ready    = (count_r != KB_FULL_CNT);
    assign push_s      = kb_valid & kb_ready;
    assign pop_s       = ~kb_full_r & (count_r != {CW{1'b0}});
    assign kbdr_read_s = kb_full_r & cpu_re & (cpu_addr == ADDR_KBDR);
    assign wr_kbsr_s   = cpu_we & (cpu_addr == ADDR_KBSR);
    assign wr_dsr_s    = cpu_we & (cpu_addr == ADDR_DSR);
    assign wr_ddr_s    = cpu_we & (cpu_addr == ADDR_DDR);
    assign dsp_rdy_s   = (dsp_state_r == DSP_IDLE);
    assign dsp_valid   = (dsp_state_r == DSP_BUSY);
    assign dsp_data    = dsp_data_r;
    assign irq         = (kb_full_r & kb_ie_r) | (dsp_rdy_s & dsp_ie_r);

    // Address decode and read-data mux for the MDR path.
    always_comb begin
        io_hit   = 1'b0;
        io_rdata = 16'h0000;
        case (cpu_addr)
            ADDR_KBSR: begin
                io_hit   = 1'b1;
                io_rdata = {kb_full_r, kb_ie_r, 14'h0000};
            end
            ADDR_KBDR: begin
                io_hit   = 1'b1;
                io_rdata = {8'h00, kbdr_r};
            end
            ADDR_DSR: begin
                io_hit   = 1'b1;
                io_rdata = {dsp_rdy_s, dsp_ie_r, 14'h0000};
            end
            ADDR_DDR: begin
                io_hit   = 1'b1;
                io_rdata = 16'h0000;
            end
            default: begin
                io_hit   = 1'b0;
                io_rdata = 16'h0000;
            end
        endcase
    end

    // Keyboard FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            kb_mem_r[wr_ptr_r] <= kb_data;
        end
    end

    // Keyboard FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // KBDR holding register; a consuming read blocks refill for that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbdr_r    <= 8'h00;
            kb_full_r <= 1'b0;
        end else if (kbdr_read_s) begin
            kb_full_r <= 1'b0;
        end else if (pop_s) begin
            kbdr_r    <= kb_mem_r[rd_ptr_r];
            kb_full_r <= 1'b1;
        end
    end

    // Interrupt-enable bits of KBSR and DSR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_ie_r  <= 1'b0;
            dsp_ie_r <= 1'b0;
        end else begin
            if (wr_kbsr_s) begin
                kb_ie_r <= cpu_wdata[14];
            end
            if (wr_dsr_s) begin
                dsp_ie_r <= cpu_wdata[14];
            end
        end
    end

    // Display FSM: DDR writes while BUSY are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsp_state_r <= DSP_IDLE;
            dsp_data_r  <= 8'h00;
        end else begin
            case (dsp_state_r)
                DSP_IDLE: begin
                    if (wr_ddr_s) begin
                        dsp_state_r <= DSP_BUSY;
                        dsp_data_r  <= cpu_wdata[7:0];
                    end
                end
                DSP_BUSY: begin
                    if (dsp_ready) begin
                        dsp_state_r <= DSP_IDLE;
                    end
                end
                default: dsp_state_r <= DSP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_console_io.sv
// Self-checking bench for lc3_console_io: directed scenarios plus random traffic against a queue-based model.
module tb_lc3_console_io;

    localparam int KB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        io_hit;
    logic [15:0] io_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_kbdr;
    bit         m_full, m_kie, m_die, m_busy;
    logic [7:0] m_ddata;

    lc3_console_io #(.KB_DEPTH(KB_DEPTH)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .io_hit(io_hit), .io_rdata(io_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic bit m_hit(input logic [15:0] a);
        return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
    endfunction

    function automatic logic [15:0] m_rdata(input logic [15:0] a);
        if (a == 16'hFE00) return {m_full, m_kie, 14'h0000};
        else if (a == 16'hFE02) return {8'h00, m_kbdr};
        else if (a == 16'hFE04) return {!m_busy, m_die, 14'h0000};
        else return 16'h0000;
    endfunction

    function automatic bit m_irq();
        return (m_full && m_kie) || (!m_busy && m_die);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_kbdr = 8'h00; m_full = 1'b0; m_kie = 1'b0; m_die = 1'b0;
        m_busy = 1'b0; m_ddata = 8'h00;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_step();
        bit do_push;
        do_push = kb_valid && (m_q.size() < KB_DEPTH);
        if (m_full && cpu_re && cpu_addr == 16'hFE02) m_full = 1'b0;
        else if (!m_full && m_q.size() > 0) begin
            m_kbdr = m_q.pop_front();
            m_full = 1'b1;
        end
        if (do_push) m_q.push_back(kb_data);
        if (cpu_we && cpu_addr == 16'hFE00) m_kie = cpu_wdata[14];
        if (cpu_we && cpu_addr == 16'hFE04) m_die = cpu_wdata[14];
        if (!m_busy) begin
            if (cpu_we && cpu_addr == 16'hFE06) begin
                m_busy = 1'b1;
                m_ddata = cpu_wdata[7:0];
            end
        end else if (dsp_ready) m_busy = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_addr = 16'h0000; cpu_wdata = 16'h0000; cpu_we = 1'b0; cpu_re = 1'b0;
        kb_valid = 1'b0; kb_data = 8'h00; dsp_ready = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        cpu_addr = a;
        #1;
        d = io_rdata;
        cpu_addr = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        cpu_addr = a; cpu_re = 1'b1;
        #1;
        d = io_rdata;
        tick();
        cpu_re = 1'b0; cpu_addr = 16'h0000;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] v);
        cpu_addr = a; cpu_wdata = v; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h0000;
    endtask

    task automatic push(input logic [7:0] b);
        kb_valid = 1'b1; kb_data = b;
        tick();
        kb_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL reset_dsr: got %h want 8000", d); end
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_kbsr: got %h want 0000", d); end
        n_tests++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_kb_ready: got %b want 1", kb_ready); end
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dsp_valid: got %b want 0", dsp_valid); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_kbd_basic();
        logic [15:0] d;
        push(8'h41);
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL kb_latency_n: got %h want 0000", d); end
        tick();
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL kb_latency_n1: got %h want 8000", d); end
        push(8'h42);
        cpu_read(16'hFE02, d);
        n_tests++; if (d !== 16'h0041) begin n_fail++; $display("FAIL kbdr_first: got %h want 0041", d); end
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL kbsr_after_read: got %h want 0000", d); end
        tick();
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL kbsr_refill: got %h want 8000", d); end
        cpu_read(16'hFE02, d);
        n_tests++; if (d !== 16'h0042) begin n_fail++; $display("FAIL kbdr_second: got %h want 0042", d); end
        cpu_read(16'hFE02, d);
        n_tests++; if (d !== 16'h0042) begin n_fail++; $display("FAIL kbdr_stale: got %h want 0042", d); end
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL kbsr_empty: got %h want 0000", d); end
    endtask

    task automatic test_kbd_full();
        logic [15:0] d;
        bit got;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b want 1", i, kb_ready); end
            kb_valid = 1'b1; kb_data = 8'h50 + 8'(i);
            tick();
        end
        n_tests++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", kb_ready); end
        kb_data = 8'h5F;
        tick();
        kb_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                peek(16'hFE00, d);
                if (d[15]) got = 1'b1;
                else tick();
            end
            n_tests++; if (!got) begin n_fail++; $display("FAIL drain_wait_%0d: kb_full never set, want 1", i); end
            cpu_read(16'hFE02, d);
            n_tests++;
            if (d !== {8'h00, 8'h50 + 8'(i)}) begin
                n_fail++; $display("FAIL drain_order_%0d: got %h want %h", i, d, {8'h00, 8'h50 + 8'(i)});
            end
            if (i == 0) begin
                n_tests++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL ready_same_cycle: got %b want 0", kb_ready); end
                tick();
                n_tests++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL ready_next_cycle: got %b want 1", kb_ready); end
            end
        end
        tick(); tick();
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL overflow_dropped: got %h want 0000", d); end
    endtask

    task automatic test_display();
        logic [15:0] d;
        dsp_ready = 1'b0;
        cpu_write(16'hFE06, 16'h0148);
        n_tests++; if (dsp_valid !== 1'b1) begin n_fail++; $display("FAIL ddr_valid: got %b want 1", dsp_valid); end
        n_tests++; if (dsp_data !== 8'h48) begin n_fail++; $display("FAIL ddr_data: got %h want 48", dsp_data); end
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL dsr_busy: got %h want 0000", d); end
        cpu_write(16'hFE06, 16'h0049);
        n_tests++; if (dsp_data !== 8'h48) begin n_fail++; $display("FAIL ddr_drop: got %h want 48", dsp_data); end
        cpu_addr = 16'hFE06;
        #1;
        n_tests++; if (io_hit !== 1'b1 || io_rdata !== 16'h0000) begin n_fail++; $display("FAIL ddr_read: got hit %b data %h want 1 0000", io_hit, io_rdata); end
        cpu_addr = 16'h0000;
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_valid: got %b want 0", dsp_valid); end
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL dsr_idle: got %h want 8000", d); end
        tick(); tick();
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL no_second_byte: got %b want 0", dsp_valid); end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        cpu_write(16'hFE00, 16'h4000);
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h4000) begin n_fail++; $display("FAIL kbsr_ie: got %h want 4000", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ie_only: got %b want 0", irq); end
        push(8'h33);
        tick();
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_kb: got %b want 1", irq); end
        cpu_write(16'hFE02, 16'h00AA);
        cpu_read(16'hFE02, d);
        n_tests++; if (d !== 16'h0033) begin n_fail++; $display("FAIL kbdr_ro: got %h want 0033", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_kb_clear: got %b want 0", irq); end
        cpu_write(16'hFE00, 16'h0000);
        cpu_write(16'hFE04, 16'h4000);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_dsp: got %b want 1", irq); end
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'hC000) begin n_fail++; $display("FAIL dsr_ie: got %h want c000", d); end
        cpu_write(16'hFE04, 16'hBFFF);
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL dsr_ro_bits: got %h want 8000", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_dsp_clear: got %b want 0", irq); end
    endtask

    task automatic test_random();
        logic [15:0] addrs [6];
        addrs = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE08, 16'h3000};
        for (int c = 0; c < 400; c++) begin
            cpu_addr  = addrs[$urandom_range(0, 5)];
            cpu_re    = ($urandom_range(0, 2) == 0);
            cpu_we    = ($urandom_range(0, 5) == 0);
            cpu_wdata = 16'($urandom);
            kb_valid  = ($urandom_range(0, 1) == 0);
            kb_data   = 8'($urandom);
            dsp_ready = ($urandom_range(0, 2) == 0);
            #1;
            n_tests++; if (io_hit !== m_hit(cpu_addr)) begin n_fail++; $display("FAIL rnd_hit c%0d: got %b want %b", c, io_hit, m_hit(cpu_addr)); end
            n_tests++; if (io_rdata !== m_rdata(cpu_addr)) begin n_fail++; $display("FAIL rnd_rdata c%0d addr %h: got %h want %h", c, cpu_addr, io_rdata, m_rdata(cpu_addr)); end
            n_tests++; if (kb_ready !== (m_q.size() < KB_DEPTH)) begin n_fail++; $display("FAIL rnd_kb_ready c%0d: got %b want %b", c, kb_ready, m_q.size() < KB_DEPTH); end
            n_tests++; if (dsp_valid !== m_busy) begin n_fail++; $display("FAIL rnd_dsp_valid c%0d: got %b want %b", c, dsp_valid, m_busy); end
            n_tests++; if (irq !== m_irq()) begin n_fail++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, m_irq()); end
            if (m_busy) begin
                n_tests++; if (dsp_data !== m_ddata) begin n_fail++; $display("FAIL rnd_dsp_data c%0d: got %h want %h", c, dsp_data, m_ddata); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        cpu_write(16'hFE06, 16'h0155);
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        n_tests++; if (dsp_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", dsp_valid); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_dsp_valid: got %b want 0", dsp_valid); end
        n_tests++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL async_kb_ready: got %b want 1", kb_ready); end
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL async_kbsr: got %h want 0000", d); end
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL async_dsr: got %h want 8000", d); end
        @(negedge clk);
        reset = 1'b1;
        tick(); tick();
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL fifo_discarded: got %h want 0000", d); end
        cpu_addr = 16'hFE08; cpu_wdata = 16'hFFFF; cpu_we = 1'b1; cpu_re = 1'b1;
        #1;
        n_tests++; if (io_hit !== 1'b0 || io_rdata !== 16'h0000) begin n_fail++; $display("FAIL miss_fe08: got hit %b data %h want 0 0000", io_hit, io_rdata); end
        tick();
        cpu_addr = 16'h3000;
        #1;
        n_tests++; if (io_hit !== 1'b0 || io_rdata !== 16'h0000) begin n_fail++; $display("FAIL miss_3000: got hit %b data %h want 0 0000", io_hit, io_rdata); end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        peek(16'hFE00, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL miss_kbsr: got %h want 0000", d); end
        peek(16'hFE04, d);
        n_tests++; if (d !== 16'h8000) begin n_fail++; $display("FAIL miss_dsr: got %h want 8000", d); end
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_dsp_valid: got %b want 0", dsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #17;
        test_reset();
        reset = 1'b1;
        tick();
        test_kbd_basic();
        test_kbd_full();
        test_display();
        test_irq();
        test_random();
        tick(); tick();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
